// File: rtl/tmds_symbol_decoder.sv
// -----------------------------------------------------------------------------
// tmds_symbol_decoder
//
// Recovers 10-bit TMDS symbol alignment from an unaligned deserialized word
// stream, then decodes each aligned symbol into a pixel byte or control pair.
//
// Alignment works by bit-slipping: a 20-bit window {in_raw, previous in_raw}
// is tapped at out_offset. While searching, the offset advances after c_dwell
// cycles without a control token. c_lock_tokens consecutive tokens at one
// offset declare lock. Lock is dropped (and the offset advanced) after c_dwell
// cycles without a token.
//
// Parameters
//   c_dwell        token-free cycles before the offset advances / lock drops
//   c_lock_tokens  consecutive tokens needed to declare lock
//
// Ports
//   clk_pixel      in   1   pixel clock, one 10-bit word per cycle
//   reset          in   1   asynchronous active-high reset
//   in_raw         in  10   unaligned TMDS bits, bit 0 earliest
//   out_data       out  8   decoded pixel byte
//   out_c          out  2   control bits {c1,c0} ({vsync,hsync} on blue)
//   out_de         out  1   1 while out_data carries video
//   out_locked     out  1   symbol alignment achieved
//   out_offset     out  4   current bit-slip offset, 0..9
//   out_err_count  out 16   lock-loss event counter
//
// Optional feature
//   TMDS_SYMBOL_DECODER_ERRCNT_EN  when defined, out_err_count counts
//   LOCKED-to-SEARCH transitions (saturating); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module tmds_symbol_decoder #(
  parameter int c_dwell       = 2048,
  parameter int c_lock_tokens = 8
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  in_raw,
  output logic [7:0]  out_data,
  output logic [1:0]  out_c,
  output logic        out_de,
  output logic        out_locked,
  output logic [3:0]  out_offset,
  output logic [15:0] out_err_count
);

  localparam int                DCNT_W      = $clog2(c_dwell) + 1;
  localparam logic [DCNT_W-1:0] DWELL_LAST  = DCNT_W'(c_dwell - 1);
  localparam logic [7:0]        LOCK_TOKENS = 8'(c_lock_tokens);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [7:0]        r_tcnt, w_tcnt_nxt;
  logic [3:0]        r_offset, w_offset_nxt;
  logic [9:0]        r_prev_raw;

  logic [18:0]       w_window;
  logic [9:0]        w_sym;
  logic              w_is_token;
  logic [1:0]        w_token_c;

  logic [7:0]        r_data;
  logic [1:0]        r_c;
  logic              r_de;
  logic              r_locked;

  // Transition-minimised decode: undo the optional inversion, then undo the
  // XOR/XNOR chain. Bit 0 of the chain is passed through unchanged.
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] x;
    d = s[9] ? ~s[7:0] : s[7:0];
    x = d ^ {d[6:0], 1'b0};
    return s[8] ? x : {~x[7:1], x[0]};
  endfunction

  function automatic logic [3:0] offset_inc(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  // Bit 19 of the full window is never reachable (max offset 9 taps [18:9]).
  assign w_window = {in_raw[8:0], r_prev_raw};

  always_comb begin
    w_sym = w_window[9:0];
    case (r_offset)
      4'd1:    w_sym = w_window[10:1];
      4'd2:    w_sym = w_window[11:2];
      4'd3:    w_sym = w_window[12:3];
      4'd4:    w_sym = w_window[13:4];
      4'd5:    w_sym = w_window[14:5];
      4'd6:    w_sym = w_window[15:6];
      4'd7:    w_sym = w_window[16:7];
      4'd8:    w_sym = w_window[17:8];
      4'd9:    w_sym = w_window[18:9];
      default: w_sym = w_window[9:0];
    endcase
  end

  always_comb begin
    w_is_token = 1'b1;
    w_token_c  = 2'b00;
    case (w_sym)
      10'h354: w_token_c = 2'b00;
      10'h0AB: w_token_c = 2'b01;
      10'h154: w_token_c = 2'b10;
      10'h2AB: w_token_c = 2'b11;
      default: w_is_token = 1'b0;
    endcase
  end

  // Alignment FSM: next state and counters
  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_tcnt_nxt   = r_tcnt;
    w_offset_nxt = r_offset;
    case (r_state)
      ST_SEARCH: begin
        if (w_is_token) begin
          w_state_nxt = ST_VERIFY;
          w_tcnt_nxt  = 8'd1;
        end else if (r_dcnt == DWELL_LAST) begin
          w_offset_nxt = offset_inc(r_offset);
          w_dcnt_nxt   = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      ST_VERIFY: begin
        if (w_is_token) begin
          w_tcnt_nxt = r_tcnt + 8'd1;
          if (r_tcnt + 8'd1 == LOCK_TOKENS) begin
            w_state_nxt = ST_LOCKED;
            w_dcnt_nxt  = '0;
          end
        end else begin
          // A data symbol breaks the run; retry the same offset from scratch.
          w_state_nxt = ST_SEARCH;
          w_dcnt_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (w_is_token) begin
          w_dcnt_nxt = '0;
        end else if (r_dcnt == DWELL_LAST) begin
          w_state_nxt  = ST_SEARCH;
          w_offset_nxt = offset_inc(r_offset);
          w_dcnt_nxt   = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  // Stage 0: FSM state, counters, offset and previous word
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SEARCH;
      r_dcnt     <= '0;
      r_tcnt     <= '0;
      r_offset   <= '0;
      r_prev_raw <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_offset   <= w_offset_nxt;
      r_prev_raw <= in_raw;
    end
  end

  // Stage 1: registered outputs for the symbol formed this cycle
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_c      <= '0;
      r_de     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= (r_state == ST_LOCKED);
      if (r_state == ST_LOCKED) begin
        if (w_is_token) begin
          r_de   <= 1'b0;
          r_c    <= w_token_c;
          r_data <= '0;
        end else begin
          // out_c keeps the last control value through active video.
          r_de   <= 1'b1;
          r_data <= tmds_decode(w_sym);
        end
      end else begin
        r_de   <= 1'b0;
        r_c    <= '0;
        r_data <= '0;
      end
    end
  end

`ifdef TMDS_SYMBOL_DECODER_ERRCNT_EN
  logic [15:0] r_err_count;
  logic        w_loss;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_loss = (r_state == ST_LOCKED) && !w_is_token && (r_dcnt == DWELL_LAST);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_loss) begin
      r_err_count <= sat_inc16(r_err_count);
    end
  end

  assign out_err_count = r_err_count;
`else
  assign out_err_count = 16'd0;
`endif

  assign out_data   = r_data;
  assign out_c      = r_c;
  assign out_de     = r_de;
  assign out_locked = r_locked;
  assign out_offset = r_offset;

endmodule

// File: doc/tmds_symbol_decoder.md
TMDS_SYMBOL_DECODER -- requirements
Module: tmds_symbol_decoder

Interface
REQ-001 Parameter c_dwell, default 2048: cycles without a control token before the bit offset advances or lock is dropped (range 16..65535).
REQ-002 Parameter c_lock_tokens, default 8: consecutive control tokens required to declare lock (range 2..255).
REQ-003 The block SHALL have one clock, clk_pixel, and an asynchronous, active-high reset, reset.
REQ-004 Ports SHALL be as follows (clock and reset first):
- clk_pixel  in  1  pixel clock; one 10-bit word per cycle.
- reset  in  1  asynchronous active-high reset.
- in_raw  in  10  unaligned deserialized TMDS bits; bit 0 is the earliest received.
- out_data  out  8  decoded pixel byte.
- out_c  out  2  control bits {c1,c0}; on the blue channel these are {vsync,hsync}.
- out_de  out  1  1 when out_data is valid video, 0 during blanking.
- out_locked  out  1  symbol alignment achieved.
- out_offset  out  4  current bit-slip offset, 0..9.
- out_err_count  out  16  lock-loss event counter (see Configuration).

Function
REQ-005 Each cycle the block SHALL form window = {in_raw, prev_raw}, where prev_raw is in_raw registered from the previous cycle; symbol s = window[offset+9 : offset].
REQ-006 Control tokens SHALL be 10'h354 (c=00), 10'h0AB (c=01), 10'h154 (c=10) and 10'h2AB (c=11); any other s is a data symbol.
REQ-007 Data decode: d = s[9] ? ~s[7:0] : s[7:0]; out_data[0] = d[0]; for i = 1..7, out_data[i] = s[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-008 Outputs SHALL be registered; symbol s computed in cycle n appears on the outputs in cycle n+1.
REQ-009 When locked, a token SHALL give out_de=0, out_c=token value, out_data=0; a data symbol SHALL give out_de=1, out_c held at its last value, out_data decoded per REQ-007.
REQ-010 When not locked, out_de, out_c and out_data SHALL be 0.
REQ-011 The FSM SHALL have the states SEARCH, VERIFY and LOCKED, with dwell counter dcnt and token counter tcnt.
REQ-012 SEARCH: a token moves the FSM to VERIFY with tcnt=1. Otherwise dcnt increments; at dcnt=c_dwell-1, offset advances (9 wraps to 0) and dcnt clears.
REQ-013 VERIFY: a token increments tcnt; reaching c_lock_tokens moves the FSM to LOCKED with dcnt=0. A data symbol returns the FSM to SEARCH with the offset unchanged and dcnt=0.
REQ-014 LOCKED: a token clears dcnt; otherwise dcnt increments. At dcnt=c_dwell-1 the FSM SHALL go to SEARCH, advance offset, clear dcnt, and count one lock-loss event.
REQ-015 An offset change SHALL take effect on the next cycle; the symbol formed in the change cycle uses the old offset.
REQ-016 Counters SHALL not wrap; dcnt width = clog2(c_dwell)+1.
REQ-017 out_locked SHALL be 1 exactly while state=LOCKED, registered with the same one-cycle timing as REQ-008.

Reset
REQ-018 Reset assertion SHALL force the state to SEARCH and set offset, dcnt, tcnt, prev_raw and all outputs to 0, including out_err_count. This applies mid-operation, including while LOCKED.
REQ-019 After reset deasserts, the first symbol SHALL be evaluated on the first clk_pixel edge.

Configuration
REQ-020 Macro TMDS_SYMBOL_DECODER_ERRCNT_EN selects the lock-loss counter.
- Defined: out_err_count increments by 1 on each LOCKED-to-SEARCH transition and saturates at 16'hFFFF.
- Undefined: out_err_count is tied to 0 and no counter logic is built.

Verification
REQ-021 Offset 3: feed a stream with 12 tokens 10'h354 per 100-word line, bit-shifted by 3 -> out_offset=3 and out_locked=1 within 4*c_dwell cycles.
REQ-022 When locked, aligned symbols 10'h100, 10'h2FF and 10'h0AB -> out_data 8'h00 (de=1), 8'hFE (de=1), then de=0 with out_c=2'b01, each one cycle after alignment.
REQ-023 VERIFY break: 5 tokens followed by data 10'h100 -> return to SEARCH with offset unchanged; 8 further tokens -> LOCKED.
REQ-024 When locked, remove all tokens for c_dwell cycles -> out_locked falls, offset increments by 1, and out_err_count=1 (macro defined) or 0 (undefined).
REQ-025 Assert reset while LOCKED with offset 7 -> next cycle shows out_locked=0, out_offset=0, out_de=0, out_c=0, and out_err_count=0.
REQ-026 At offset 9 in SEARCH, c_dwell token-free cycles -> out_offset=0 (wrap).
